// File: rtl/regfile_arb_pkg.sv
// Shared constants for the register-file write-back arbiter.
// Holds the default requester/register counts, bus widths, the program
// counter register index and the requester index names.
package regfile_arb_pkg;

  localparam int NUM_REQ  = 3;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;
  localparam int PC_INDEX = 15;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_LINK = 2;

  // Width of a requester index; never narrower than one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority one-hot picker.
// The requester just after LAST has highest priority, then LAST+2, ...
// wrapping modulo NUM_REQ. With LAST tied to NUM_REQ-1 this reduces to
// fixed priority 0 > 1 > 2.
// Ports:
//   REQ   in  NUM_REQ  request vector
//   LAST  in  LAST_W   index of the most recently granted requester
//   GNT   out NUM_REQ  one-hot (or zero) pick
module rr_priority_pick #(
  parameter int NUM_REQ = 3,
  parameter int LAST_W  = 2
) (
  input  logic [NUM_REQ-1:0] REQ,
  input  logic [LAST_W-1:0]  LAST,
  output logic [NUM_REQ-1:0] GNT
);

  logic w_found;

  // Walk the priority ring starting after LAST; the first requester seen wins.
  always_comb begin
    GNT     = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && REQ[i] && (((int'(LAST) + k) % NUM_REQ) == i)) begin
          GNT[i]  = 1'b1;
          w_found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-back arbiter.
// Picks one of NUM_REQ write requesters per cycle and drives a registered
// one-hot enable and a shared data bus into NUM_REGS 32-bit registers.
// Build option: define REGFILE_ARB_ROUND_ROBIN_EN for round-robin
// arbitration with a LAST pointer; otherwise fixed priority 0 > 1 > 2.
// Ports:
//   CLK       in   rising-edge clock
//   RESET     in   asynchronous active-low reset
//   HOLD      in   stall, forces all grants low
//   REQ       in   per-requester write request
//   REQ_ADDR  in   per-requester destination register index
//   REQ_DATA  in   per-requester write data
//   GNT       out  per-requester grant (combinational)
//   REG_EN    out  one-hot register enable (registered)
//   REG_D     out  shared register D bus (registered)
//   PC_WR     out  write to the PC register presented this cycle (registered)
//   BUSY      out  requests pending with no grant this cycle
module regfile_write_arbiter #(
  parameter int NUM_REQ  = regfile_arb_pkg::NUM_REQ,
  parameter int NUM_REGS = regfile_arb_pkg::NUM_REGS
) (
  input  logic                                      CLK,
  input  logic                                      RESET,
  input  logic                                      HOLD,
  input  logic [NUM_REQ-1:0]                        REQ,
  input  logic [NUM_REQ*regfile_arb_pkg::ADDR_W-1:0] REQ_ADDR,
  input  logic [NUM_REQ*regfile_arb_pkg::DATA_W-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]                        GNT,
  output logic [NUM_REGS-1:0]                       REG_EN,
  output logic [regfile_arb_pkg::DATA_W-1:0]        REG_D,
  output logic                                      PC_WR,
  output logic                                      BUSY
);

  import regfile_arb_pkg::*;

  localparam int LAST_W = ptr_w(NUM_REQ);

  logic [LAST_W-1:0]   w_last;
  logic [NUM_REQ-1:0]  w_pick;
  logic                w_xfer;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [DATA_W-1:0]   w_win_data;
  logic [NUM_REGS-1:0] w_en_dec;
  logic                w_pc_hit;

  logic [NUM_REGS-1:0] r_reg_en;
  logic [DATA_W-1:0]   r_reg_d;
  logic                r_pc_wr;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  logic [LAST_W-1:0] r_last;
  logic [LAST_W-1:0] w_win_idx;

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GNT[i]) w_win_idx = LAST_W'(i);
    end
  end

  // Reset value NUM_REQ-1 puts requester 0 first in line.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)      r_last <= LAST_W'(NUM_REQ - 1);
    else if (w_xfer) r_last <= w_win_idx;
  end

  assign w_last = r_last;
`else
  assign w_last = LAST_W'(NUM_REQ - 1);
`endif

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .LAST_W  (LAST_W)
  ) u_pick (
    .REQ  (REQ),
    .LAST (w_last),
    .GNT  (w_pick)
  );

  // Grants are suppressed combinationally so nothing transfers in reset or stall.
  assign GNT    = (RESET && !HOLD) ? w_pick : '0;
  assign w_xfer = |GNT;
  assign BUSY   = (|REQ) && !(|GNT);

  always_comb begin
    w_win_addr = '0;
    w_win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GNT[i]) begin
        w_win_addr = REQ_ADDR[i*ADDR_W +: ADDR_W];
        w_win_data = REQ_DATA[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_en_dec = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      w_en_dec[k] = (w_win_addr == ADDR_W'(k));
    end
  end

  assign w_pc_hit = (w_win_addr == ADDR_W'(PC_INDEX));

  // REG_D keeps its last value between transfers; only the enable pulses.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_reg_en <= '0;
      r_reg_d  <= '0;
      r_pc_wr  <= 1'b0;
    end else if (w_xfer) begin
      r_reg_en <= w_en_dec;
      r_reg_d  <= w_win_data;
      r_pc_wr  <= w_pc_hit;
    end else begin
      r_reg_en <= '0;
      r_pc_wr  <= 1'b0;
    end
  end

  assign REG_EN = r_reg_en;
  assign REG_D  = r_reg_d;
  assign PC_WR  = r_pc_wr;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_regfile_write_arbiter;

  localparam int NR = 3;
  localparam int NG = 16;

  logic            CLK = 1'b0;
  logic            RESET = 1'b0;
  logic            HOLD = 1'b0;
  logic [NR-1:0]   REQ = '0;
  logic [NR*4-1:0] REQ_ADDR = '0;
  logic [NR*32-1:0] REQ_DATA = '0;
  logic [NR-1:0]   GNT;
  logic [NG-1:0]   REG_EN;
  logic [31:0]     REG_D;
  logic            PC_WR;
  logic            BUSY;

  regfile_write_arbiter #(.NUM_REQ(NR), .NUM_REGS(NG)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .HOLD     (HOLD),
    .REQ      (REQ),
    .REQ_ADDR (REQ_ADDR),
    .REQ_DATA (REQ_DATA),
    .GNT      (GNT),
    .REG_EN   (REG_EN),
    .REG_D    (REG_D),
    .PC_WR    (PC_WR),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state: pending register write, held data bus, pointer, register files.
  int           m_en_idx = -1;
  logic [31:0]  m_d = 32'h0;
  int           m_last = NR - 1;
  logic [NR-1:0] m_xfer_vec = '0;
  logic [31:0]  m_rf [NG];
  logic [31:0]  d_rf [NG];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester with the smallest ring distance after 'last' wins.
  function automatic int model_pick(input logic [NR-1:0] req, input logic hold,
                                    input logic rst, input int last);
    if (!rst || hold) return -1;
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (last + k) % NR;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge CLK or negedge RESET) begin
    int g;
    if (!RESET) begin
      m_en_idx   = -1;
      m_d        = 32'h0;
      m_last     = NR - 1;
      m_xfer_vec = '0;
    end else begin
      if (m_en_idx >= 0) m_rf[m_en_idx] = m_d;
      g = model_pick(REQ, HOLD, 1'b1, m_last);
      m_xfer_vec = '0;
      if (g >= 0) begin
        m_xfer_vec[g] = 1'b1;
        m_en_idx = int'(REQ_ADDR[g*4 +: 4]);
        m_d      = REQ_DATA[g*32 +: 32];
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
        m_last   = g;
`endif
      end else begin
        m_en_idx = -1;
      end
    end
  end

  // The registers the arbiter feeds, built from the DUT's own outputs.
  always @(posedge CLK) begin
    for (int k = 0; k < NG; k++) begin
      if (REG_EN[k]) d_rf[k] <= REG_D;
    end
  end

  always @(negedge CLK) begin
    int g;
    logic [31:0] exp_gnt;
    logic [31:0] exp_en;
    if (chk_en) begin
      g       = model_pick(REQ, HOLD, RESET, m_last);
      exp_gnt = (g >= 0) ? (32'h1 << g) : 32'h0;
      exp_en  = (m_en_idx >= 0) ? (32'h1 << m_en_idx) : 32'h0;
      check("gnt",    32'(GNT),    exp_gnt);
      check("busy",   32'(BUSY),   32'((|REQ) && (g < 0)));
      check("reg_en", 32'(REG_EN), exp_en);
      check("reg_d",  REG_D,       m_d);
      check("pc_wr",  32'(PC_WR),  32'(m_en_idx == 15));
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  function automatic int gnt_idx(input logic [NR-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (g[i]) r = i;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gseq [6];
    int exp_seq;
    for (int k = 0; k < NG; k++) begin
      m_rf[k] = 32'h0;
      d_rf[k] = 32'h0;
    end

    repeat (3) @(posedge CLK);
    #2;
    RESET    = 1'b1;
    REQ_ADDR = {4'd9, 4'd8, 4'd7};
    REQ_DATA = {32'hC0C0_0002, 32'hB0B0_0001, 32'hA0A0_0000};
    REQ      = 3'b111;
    chk_en   = 1'b1;

    // All three requesting from a fresh reset.
    for (int s = 0; s < 6; s++) begin
      #1 gseq[s] = gnt_idx(GNT);
      cyc();
    end
    for (int s = 0; s < 6; s++) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
      exp_seq = s % 3;
`else
      exp_seq = 0;
`endif
      check($sformatf("grant_order_%0d", s), 32'(gseq[s]), 32'(exp_seq));
    end

    // Reset right after a transfer, with all requests still up.
    RESET = 1'b0;
    #1;
    check("rst_gnt",    32'(GNT),    32'h0);
    check("rst_reg_en", 32'(REG_EN), 32'h0);
    check("rst_reg_d",  REG_D,       32'h0);
    cyc();
    RESET = 1'b1;
    #1 check("rst_first_gnt", 32'(GNT), 32'h1);
    cyc();
    REQ = 3'b000;
    #1 check("rst_first_en", 32'(REG_EN), 32'h0080);

    // Single write to R5.
    REQ_ADDR[3:0]  = 4'd5;
    REQ_DATA[31:0] = 32'hDEAD_BEEF;
    REQ            = 3'b001;
    cyc();
    REQ = 3'b000;
    #1;
    check("single_en",   32'(REG_EN), 32'h0020);
    check("single_d",    REG_D,       32'hDEAD_BEEF);
    check("single_pcwr", 32'(PC_WR),  32'h0);

    // Branch-link write to the PC.
    REQ_ADDR[11:8]  = 4'd15;
    REQ_DATA[95:64] = 32'h0000_1000;
    REQ             = 3'b100;
    cyc();
    REQ = 3'b000;
    #1;
    check("pc_en",   32'(REG_EN), 32'h8000);
    check("pc_wr",   32'(PC_WR),  32'h1);
    cyc();
    #1;
    check("pc_wr_drop", 32'(PC_WR),  32'h0);
    check("pc_en_drop", 32'(REG_EN), 32'h0);
    check("pc_d_hold",  REG_D,       32'h0000_1000);

    // Stall with two requesters waiting; requester 0 went last.
    REQ_ADDR[3:0]  = 4'd4;
    REQ_DATA[31:0] = 32'h0000_0044;
    REQ            = 3'b001;
    cyc();
    HOLD            = 1'b1;
    REQ_ADDR[7:4]   = 4'd6;
    REQ_DATA[63:32] = 32'h0000_0066;
    REQ             = 3'b011;
    for (int h = 0; h < 3; h++) begin
      #1;
      check($sformatf("hold_gnt_%0d", h),  32'(GNT),  32'h0);
      check($sformatf("hold_busy_%0d", h), 32'(BUSY), 32'h1);
      cyc();
      check($sformatf("hold_en_%0d", h), 32'(REG_EN), 32'h0);
    end
    HOLD = 1'b0;
    #1;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    check("hold_resume", 32'(GNT), 32'h2);
`else
    check("hold_resume", 32'(GNT), 32'h1);
`endif
    cyc();
    cyc();
    REQ = 3'b000;
    cyc();

    // Two requesters hitting R3 on consecutive cycles.
    REQ_ADDR[3:0]   = 4'd3;
    REQ_DATA[31:0]  = 32'h0000_0001;
    REQ             = 3'b001;
    cyc();
    REQ_ADDR[7:4]   = 4'd3;
    REQ_DATA[63:32] = 32'h0000_0002;
    REQ             = 3'b010;
    cyc();
    REQ = 3'b000;
    cyc();
    cyc();
    check("same_target_r3", d_rf[3], 32'h0000_0002);

    // Randomized traffic; a waiting requester keeps its address and data.
    for (int c = 0; c < 400; c++) begin
      cyc();
      RESET = ($urandom_range(0, 63) != 0);
      HOLD  = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NR; i++) begin
        if (!REQ[i] || m_xfer_vec[i]) begin
          REQ[i]              = 1'($urandom_range(0, 1));
          REQ_ADDR[i*4 +: 4]  = 4'($urandom_range(0, 15));
          REQ_DATA[i*32 +: 32] = $urandom;
        end
      end
    end
    REQ   = '0;
    HOLD  = 1'b0;
    RESET = 1'b1;
    repeat (3) cyc();
    for (int k = 0; k < NG; k++) begin
      check($sformatf("final_r%0d", k), d_rf[k], m_rf[k]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 3, number of write-back requesters; NUM_REGS, default 16, number of 32-bit registers driven.
REQ-002 Ports SHALL be as follows, one per line:
  CLK  input  1  rising-edge clock
  RESET  input  1  asynchronous, active-low reset
  HOLD  input  1  stall; forces all grants low
  REQ  input  NUM_REQ  per-requester write request (0=ALU, 1=load, 2=branch-link)
  REQ_ADDR  input  NUM_REQ*4  per-requester destination register index
  REQ_DATA  input  NUM_REQ*32  per-requester write data
  GNT  output  NUM_REQ  per-requester grant, combinational
  REG_EN  output  NUM_REGS  one-hot ENABLE to each 32-bit register, registered
  REG_D  output  32  shared D bus to all registers, registered
  PC_WR  output  1  write to register 15 issued this cycle, registered
  BUSY  output  1  REQ has any bit high and no grant this cycle

Function
REQ-003 A transfer SHALL occur for requester i at a rising CLK edge where REQ[i] and GNT[i] are both high.
REQ-004 GNT SHALL be at most one-hot; GNT SHALL be all-zero when HOLD is high or REQ is zero.
REQ-005 Requester i SHALL keep REQ_ADDR/REQ_DATA stable while REQ[i] is high and GNT[i] is low; the arbiter SHALL NOT latch them at any other time.
REQ-006 On a transfer, the cycle after the edge SHALL present REG_EN = one-hot(REQ_ADDR[i]) and REG_D = REQ_DATA[i]; the target register captures at the following edge (accept-to-register latency 2 edges).
REQ-007 In any cycle with no transfer at the preceding edge, REG_EN SHALL be all-zero and PC_WR low; REG_D SHALL hold its last value.
REQ-008 PC_WR SHALL be high exactly in cycles where REG_EN[15] is high.
REQ-009 Back-to-back transfers SHALL be supported: one transfer per cycle, including repeated transfers from the same requester.
REQ-010 Two requesters targeting the same register in successive cycles SHALL be written in grant order; the later write wins.
REQ-011 Winner selection SHALL use a pointer LAST (index of last granted requester); priority order is LAST+1, LAST+2, ... modulo NUM_REQ.
REQ-012 LAST SHALL update only at edges where a transfer occurs; HOLD SHALL freeze LAST.
REQ-013 BUSY SHALL equal (|REQ) AND NOT(|GNT).

Reset
REQ-014 RESET low SHALL asynchronously clear REG_EN to zero, REG_D to 0x00000000, PC_WR to 0, and set LAST to NUM_REQ-1 (requester 0 highest after reset).
REQ-015 While RESET is low, GNT SHALL be all-zero and no transfer SHALL occur.
REQ-016 Reset asserted in the cycle after a transfer SHALL clear REG_EN before the next edge; the pending register write is discarded.
REQ-017 First transfer after reset release SHALL be accepted at the first rising edge with RESET high.

Configuration
REQ-018 Macro REGFILE_ARB_ROUND_ROBIN_EN defined: arbitration SHALL be round-robin per REQ-011/REQ-012.
REQ-019 Macro undefined: arbitration SHALL be fixed priority 0 > 1 > 2; LAST register SHALL NOT exist; all other behaviour is unchanged.

Structure
REQ-020 Shared package regfile_arb_pkg SHALL hold NUM_REQ, NUM_REGS, ADDR_W=4, DATA_W=32, PC_INDEX=15 and requester index constants REQ_ALU=0, REQ_LOAD=1, REQ_LINK=2.
REQ-021 One sub-module, rr_priority_pick, SHALL implement the rotating-priority one-hot picker (inputs REQ and LAST, output GNT); the top level holds pointer, decode and output registers.
REQ-022 REG_EN SHALL wire bit k to the ENABLE of register k; REG_D SHALL fan out to all register D inputs.

Verification
REQ-023 Reset: RESET low mid-stream with REQ=3'b111 -> GNT=0, REG_EN=0, REG_D=0x00000000; after release, first grant goes to requester 0.
REQ-024 Single write: REQ[0], ADDR=5, DATA=0xDEADBEEF -> next cycle REG_EN=0x0020, REG_D=0xDEADBEEF, PC_WR=0.
REQ-025 Round-robin: REQ=3'b111 held for 6 cycles -> grant order 0,1,2,0,1,2; fixed-priority build -> 0 every cycle.
REQ-026 PC write: REQ[2], ADDR=15, DATA=0x00001000 -> REG_EN=0x8000, PC_WR=1 for exactly one cycle.
REQ-027 HOLD: HOLD=1 for 3 cycles with REQ=3'b011 -> GNT=0, BUSY=1, REG_EN=0; on HOLD=0, grant resumes at the requester following LAST.
REQ-028 Same target: requester 0 writes R3=0x1 then requester 1 writes R3=0x2 in consecutive cycles -> R3 ends at 0x2.
